// File: rtl/expr_check_pkg.sv
// Shared state type, signature taps and the expression evaluator for expr_check_pipe.
// The evaluator takes every shape parameter as an argument so one body serves any build.
package expr_check_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Feedback taps for the stream signature: bits 15, 13, 12 and 10.
    localparam logic [15:0] SIG_TAPS = 16'hB400;
    localparam int          MAX_W    = 64;

    // Returns sel ? ({rep{a[hi:lo]}, const} & mask) : (!b >> shamt).
    // Only the low ow bits are meaningful; the caller truncates.
    function automatic logic [MAX_W-1:0] expr_eval(
        input logic [MAX_W-1:0] a,
        input logic             b,
        input int               ow,
        input int               field_hi,
        input int               field_lo,
        input int               rep,
        input int               cw,
        input logic [MAX_W-1:0] const_v,
        input logic [MAX_W-1:0] mask,
        input int               shamt
    );
        logic [MAX_W-1:0] t_arm;
        logic [MAX_W-1:0] f_arm;
        int               fw;
        int               k;
        fw    = field_hi - field_lo + 1;
        t_arm = '0;
        f_arm = '0;
        // Walk only the result bits; the constant sits below the replicated field.
        for (int j = 0; j < MAX_W; j++) begin
            if (j < ow) begin
                if (j < cw) begin
                    t_arm[j] = const_v[j] & mask[j];
                end else begin
                    k = j - cw;
                    if (k < rep * fw) begin
                        t_arm[j] = mask[j] & (|((a >> (field_lo + k % fw)) & MAX_W'(1)));
                    end
                end
            end
        end
        if (shamt == 0 && ow > 0) begin
            f_arm[0] = ~b;
        end
        return a[0] ? t_arm : f_arm;
    endfunction

endpackage

// File: rtl/expr_check_stage.sv
// One pipeline register of expr_check_pipe carrying {valid, res, err}.
// Holds everything on stall; data only loads with a valid beat so results persist.
module expr_check_stage #(
    parameter int OW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hold,
    input  logic          in_valid,
    input  logic [OW-1:0] in_res,
    input  logic          in_err,
    output logic          out_valid,
    output logic [OW-1:0] out_res,
    output logic          out_err
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_res   <= '0;
            out_err   <= 1'b0;
        end else if (!hold) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_res <= in_res;
                out_err <= in_err;
            end
        end
    end

endmodule

// File: rtl/expr_check_pipe.sv
// Clocked expression checker: evaluates, pipelines and compares each beat against its expected value.
// Optional stream signature output enabled by EXPR_CHECK_SIGNATURE_EN.
module expr_check_pipe
    import expr_check_pkg::*;
#(
    parameter int DW       = 8,
    parameter int OW       = 2,
    parameter int FIELD_HI = 3,
    parameter int FIELD_LO = 1,
    parameter int REP      = 7,
    parameter int CW       = 12,
    parameter int CONST    = 201,
    parameter int MASK     = 2,
    parameter int SHAMT    = 15,
    parameter int DEPTH    = 2,
    parameter int ECW      = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [DW-1:0]  in_a,
    input  logic           in_b,
    input  logic [OW-1:0]  in_exp,
    input  logic           in_last,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [OW-1:0]  out_res,
    output logic           out_err,
    output logic           err_sticky,
    output logic [ECW-1:0] err_cnt,
    output logic           busy,
    output logic           done
`ifdef EXPR_CHECK_SIGNATURE_EN
    ,
    output logic [15:0]    sig
`endif
);

    localparam logic [ECW-1:0] ERR_MAX = {ECW{1'b1}};

    // Handshake: a beat moves on a cycle where valid and ready are both high;
    // ready never depends on valid, and a stalled output holds every stage.
    state_t        state_q, state_d;
    logic          last_taken_q, last_taken_d;
    logic          clr;
    logic          stall, accept, handshake, pipe_empty;
    logic [DEPTH:0] v, e;
    logic [OW-1:0] r [DEPTH+1];

    assign stall      = out_valid && !out_ready;
    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign in_ready   = busy && !last_taken_q && !stall;
    assign accept     = in_valid && in_ready;
    assign handshake  = out_valid && out_ready;
    assign pipe_empty = ~|v[DEPTH:1];

    assign v[0] = accept;
    assign r[0] = OW'(expr_eval(MAX_W'(in_a), in_b, OW, FIELD_HI, FIELD_LO, REP, CW,
                                MAX_W'(CONST), MAX_W'(MASK), SHAMT));
    assign e[0] = (r[0] != in_exp);

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        expr_check_stage #(.OW(OW)) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .hold      (stall),
            .in_valid  (v[i]),
            .in_res    (r[i]),
            .in_err    (e[i]),
            .out_valid (v[i+1]),
            .out_res   (r[i+1]),
            .out_err   (e[i+1])
        );
    end

    assign out_valid = v[DEPTH];
    assign out_res   = r[DEPTH];
    assign out_err   = e[DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_taken_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_taken_q <= last_taken_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_taken_d = last_taken_q;
        clr          = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    clr     = 1'b1;
                end
            end
            RUN: begin
                // No beat can be accepted once last is taken, so the two branches never overlap.
                if (last_taken_q && pipe_empty) begin
                    state_d      = DONE;
                    last_taken_d = 1'b0;
                end else if (accept && in_last) begin
                    last_taken_d = 1'b1;
                end
            end
            DONE: begin
                if (start) begin
                    state_d = RUN;
                    clr     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky <= 1'b0;
            err_cnt    <= '0;
        end else if (clr) begin
            err_sticky <= 1'b0;
            err_cnt    <= '0;
        end else if (handshake && out_err) begin
            err_sticky <= 1'b1;
            if (err_cnt != ERR_MAX) begin
                err_cnt <= err_cnt + ECW'(1);
            end
        end
    end

`ifdef EXPR_CHECK_SIGNATURE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= '0;
        end else if (clr) begin
            sig <= '0;
        end else if (handshake) begin
            sig <= {sig[14:0], ^(sig & SIG_TAPS)} ^ 16'(out_res);
        end
    end
`endif

endmodule

// File: tb/tb_expr_check_pipe.sv
// Self-checking bench for expr_check_pipe: a default build and a variant with a live
// true arm, SHAMT=0 and a 2-bit error counter, both driven by the same stimulus.
module tb_expr_check_pipe;

  localparam int D = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, in_valid, in_b, in_last, out_ready;
  logic [7:0] in_a;
  logic [1:0] in_exp;
  logic [1:0] in_ready_w, out_valid_w, out_err_w, sticky_w, busy_w, done_w;
  logic [1:0] out_res_w [2];
  logic [7:0] err_cnt0;
  logic [1:0] err_cnt1;
`ifdef EXPR_CHECK_SIGNATURE_EN
  logic [15:0] sig_w [2];
`endif

  expr_check_pipe u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .in_a(in_a), .in_b(in_b), .in_exp(in_exp), .in_last(in_last), .out_valid(out_valid_w[0]),
    .out_ready(out_ready), .out_res(out_res_w[0]), .out_err(out_err_w[0]),
    .err_sticky(sticky_w[0]), .err_cnt(err_cnt0), .busy(busy_w[0]), .done(done_w[0])
`ifdef EXPR_CHECK_SIGNATURE_EN
    , .sig(sig_w[0])
`endif
  );

  expr_check_pipe #(.SHAMT(0), .CW(1), .CONST(1), .MASK(3), .ECW(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .in_a(in_a), .in_b(in_b), .in_exp(in_exp), .in_last(in_last), .out_valid(out_valid_w[1]),
    .out_ready(out_ready), .out_res(out_res_w[1]), .out_err(out_err_w[1]),
    .err_sticky(sticky_w[1]), .err_cnt(err_cnt1), .busy(busy_w[1]), .done(done_w[1])
`ifdef EXPR_CHECK_SIGNATURE_EN
    , .sig(sig_w[1])
`endif
  );

  // Reference model: run phase 0=idle 1=run 2=done, D result slots, error tallies.
  int tests = 0;
  int fails = 0;
  int p_shamt [2] = '{15, 0};
  int p_cw    [2] = '{12, 1};
  int p_const [2] = '{201, 1};
  int p_mask  [2] = '{2, 3};
  int mmax    [2] = '{255, 3};
  int         mst;
  logic       mlast;
  logic       mv [D];
  logic [1:0] mr [2][D];
  logic       me [2][D];
  logic       msticky [2];
  int         mcnt [2];
  logic [15:0] msig [2];
  logic       m_acc;

  function automatic logic [1:0] ref_res(input int k, input logic [7:0] a, input logic b);
    logic [63:0] cat, fld, t, f;
    fld = 64'((a >> 1) & 8'd7);
    cat = 64'd0;
    for (int i = 0; i < 7; i++) cat = (cat << 3) | fld;
    cat = (cat << p_cw[k]) | (64'(p_const[k]) & ((64'd1 << p_cw[k]) - 64'd1));
    t = cat & 64'(p_mask[k]);
    f = (b ? 64'd0 : 64'd1) >> p_shamt[k];
    return a[0] ? t[1:0] : f[1:0];
  endfunction

  task automatic check(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s dut%0d got=%0h exp=%0h", tag, k, got, exp);
    end
  endtask

  task automatic model_reset();
    mst = 0;
    mlast = 1'b0;
    for (int i = 0; i < D; i++) begin
      mv[i] = 1'b0;
      for (int k = 0; k < 2; k++) begin
        mr[k][i] = 2'b00;
        me[k][i] = 1'b0;
      end
    end
    for (int k = 0; k < 2; k++) begin
      msticky[k] = 1'b0;
      mcnt[k] = 0;
      msig[k] = 16'h0;
    end
  endtask

  task automatic check_outputs(input logic rdy);
    for (int k = 0; k < 2; k++) begin
      check("in_ready", k, 32'(in_ready_w[k]), 32'(rdy));
      check("out_valid", k, 32'(out_valid_w[k]), 32'(mv[D-1]));
      check("busy", k, 32'(busy_w[k]), 32'(mst == 1));
      check("done", k, 32'(done_w[k]), 32'(mst == 2));
      check("err_sticky", k, 32'(sticky_w[k]), 32'(msticky[k]));
      check("err_cnt", k, (k == 0) ? 32'(err_cnt0) : 32'(err_cnt1), 32'(mcnt[k]));
      if (mv[D-1] || mst == 2) begin
        check("out_res", k, 32'(out_res_w[k]), 32'(mr[k][D-1]));
        check("out_err", k, 32'(out_err_w[k]), 32'(me[k][D-1]));
      end
`ifdef EXPR_CHECK_SIGNATURE_EN
      check("sig", k, 32'(sig_w[k]), 32'(msig[k]));
`endif
    end
  endtask

  // One clock: drive at the falling edge, check 1ns later, advance the model over the rising edge.
  task automatic step(input logic st, input logic iv, input logic [7:0] a, input logic b,
                      input logic [1:0] ex, input logic lst, input logic ordy);
    logic stall, rdy, hs, empty;
    start = st; in_valid = iv; in_a = a; in_b = b; in_exp = ex; in_last = lst; out_ready = ordy;
    #1;
    stall = mv[D-1] && !ordy;
    rdy = (mst == 1) && !mlast && !stall;
    check_outputs(rdy);
    m_acc = iv && rdy;
    hs = mv[D-1] && ordy;
    empty = 1'b1;
    for (int i = 0; i < D; i++) if (mv[i]) empty = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (hs) begin
        if (me[k][D-1]) begin
          msticky[k] = 1'b1;
          if (mcnt[k] < mmax[k]) mcnt[k]++;
        end
        msig[k] = {msig[k][14:0], msig[k][15] ^ msig[k][13] ^ msig[k][12] ^ msig[k][10]}
                  ^ {14'd0, mr[k][D-1]};
      end
    end
    if (!stall) begin
      for (int i = D - 1; i > 0; i--) begin
        if (mv[i-1]) for (int k = 0; k < 2; k++) begin
          mr[k][i] = mr[k][i-1];
          me[k][i] = me[k][i-1];
        end
        mv[i] = mv[i-1];
      end
      mv[0] = m_acc;
      if (m_acc) for (int k = 0; k < 2; k++) begin
        mr[k][0] = ref_res(k, a, b);
        me[k][0] = (mr[k][0] != ex);
      end
    end
    if (mst == 1) begin
      if (mlast && empty) begin
        mst = 2;
        mlast = 1'b0;
      end else if (m_acc && lst) begin
        mlast = 1'b1;
      end
    end else if (st) begin
      mst = 1;
      for (int k = 0; k < 2; k++) begin
        msticky[k] = 1'b0;
        mcnt[k] = 0;
        msig[k] = 16'h0;
      end
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    #1;
    model_reset();
    check_outputs(1'b0);
    for (int k = 0; k < 2; k++) begin
      check("rst_out_res", k, 32'(out_res_w[k]), 32'd0);
      check("rst_out_err", k, 32'(out_err_w[k]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_beat(input logic [7:0] a, input logic b, input logic [1:0] ex,
                           input logic lst, input logic ordy);
    int n = 0;
    m_acc = 1'b0;
    while (!m_acc && n < 20) begin
      step(1'b0, 1'b1, a, b, ex, lst, ordy);
      n++;
    end
    tests++;
    assert (m_acc) else begin
      fails++;
      $error("FAIL accept_timeout dut0 got=%0d exp=1", m_acc);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (mst != 2 && n < 40) begin
      step(1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'($urandom_range(0, 3) != 0));
      n++;
    end
    step(1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) check("drain_done", k, 32'(done_w[k]), 32'd1);
  endtask

  task automatic random_run(input int nbeats);
    int sent = 0;
    int cyc = 0;
    logic pend = 1'b0;
    logic [7:0] a = 8'h00;
    logic b = 1'b0;
    logic [1:0] ex = 2'b00;
    step(1'b1, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b1);
    while (mst != 2 && cyc < 2000) begin
      if (!pend && sent < nbeats && $urandom_range(0, 3) != 0) begin
        a = 8'($urandom);
        b = 1'($urandom_range(0, 1));
        ex = ($urandom_range(0, 1) != 0) ? ref_res(0, a, b) : 2'($urandom_range(0, 3));
        pend = 1'b1;
      end
      step(1'($urandom_range(0, 15) == 0), pend, a, b, ex, 1'(sent == nbeats - 1),
           1'($urandom_range(0, 3) != 0));
      if (m_acc) begin
        pend = 1'b0;
        sent++;
      end
      cyc++;
    end
    for (int k = 0; k < 2; k++) check("run_done", k, 32'(done_w[k]), 32'd1);
  endtask

  initial begin
    in_a = 8'h00; in_b = 1'b0; in_exp = 2'b00;
    apply_reset();

    // Single beat, last on the first beat.
    step(1'b1, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b1);
    send_beat(8'hFE, 1'b0, 2'b00, 1'b1, 1'b1);
    drain();

    // Two mismatching beats against the default build.
    step(1'b1, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b1);
    send_beat(8'hFF, 1'b0, 2'b01, 1'b0, 1'b1);
    send_beat(8'h01, 1'b0, 2'b01, 1'b1, 1'b1);
    drain();

    // False arm with zero shift on the variant.
    step(1'b1, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b1);
    send_beat(8'h00, 1'b0, 2'b01, 1'b1, 1'b1);
    drain();

    // Full pipeline held by downstream back-pressure, then released.
    step(1'b1, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(8'h03 + i), 1'b0, 2'b01, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0);
    send_beat(8'h07, 1'b1, 2'b01, 1'b1, 1'b1);
    drain();

    // Five mismatches on both builds: the 2-bit counter saturates.
    step(1'b1, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) send_beat(8'h01, 1'b0, 2'b10, 1'(i == 4), 1'b1);
    drain();

    // Randomized runs, including stray start pulses while running.
    random_run(1);
    random_run(12);
    random_run(40);

    // Reset with beats in flight, then a clean one-beat run.
    step(1'b1, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b1);
    send_beat(8'h01, 1'b0, 2'b10, 1'b0, 1'b0);
    send_beat(8'h05, 1'b1, 2'b10, 1'b0, 1'b0);
    apply_reset();
    step(1'b1, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b1);
    send_beat(8'hFE, 1'b0, 2'b00, 1'b1, 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
